// File: rtl/moving_average_filter_cfg.sv
// Boxcar moving-average filter: mean of the last 2**k accepted samples, with a runtime window,
// signed/unsigned mode, optional round-half-up and a synchronous flush.
//
//   state  | meaning
//   S_FILL | fewer than N samples since the last flush; no results emitted
//   S_RUN  | window full; every accepted sample emits a result
module moving_average_filter_cfg #(
  parameter int DATA_WIDTH = 8,
  parameter int LOG2_NMAX  = 3,
  parameter int SIGNED     = 0,
  parameter int ROUND      = 0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               clr,
  input  logic [$clog2(LOG2_NMAX+1)-1:0]     win_sel,
  input  logic                               in_valid,
  input  logic [DATA_WIDTH-1:0]              data_in,
  output logic                               out_valid,
  output logic [DATA_WIDTH-1:0]              data_out,
  output logic                               filled
);

  localparam int KW   = $clog2(LOG2_NMAX + 1);
  localparam int NMAX = 2 ** LOG2_NMAX;
  localparam int AW   = DATA_WIDTH + LOG2_NMAX;
  localparam int CW   = LOG2_NMAX + 1;
  localparam int PW   = LOG2_NMAX;

  typedef enum logic {S_FILL, S_RUN} state_t;

  state_t                state, state_d;
  logic [CW-1:0]         count, count_d;
  logic [AW-1:0]         acc, acc_d;
  logic [PW-1:0]         wr_ptr, wr_ptr_d;
  logic [KW-1:0]         k_reg, k_new, k_use;
  logic                  k_loaded;
  logic                  out_valid_d;
  logic [DATA_WIDTH-1:0] data_out_d;
  logic [DATA_WIDTH-1:0] mem [NMAX];

  logic                  flush, accept;
  logic [CW-1:0]         n_win;
  logic [PW-1:0]         old_idx;
  logic [AW-1:0]         ext_in, ext_old, acc_new, rnd, sum;
  logic [DATA_WIDTH-1:0] res_s, res_u;

  always_comb begin
    k_new   = (int'(win_sel) > LOG2_NMAX) ? KW'(LOG2_NMAX) : win_sel;
    // The very first clock after reset adopts win_sel without treating it as a window change.
    k_use   = k_loaded ? k_reg : k_new;
    flush   = clr || (k_loaded && (k_new != k_reg));
    accept  = in_valid && !flush;
    n_win   = CW'(1) << k_use;
    old_idx = wr_ptr - PW'(n_win);
    if (SIGNED != 0) begin
      ext_in  = {{LOG2_NMAX{data_in[DATA_WIDTH-1]}}, data_in};
      ext_old = {{LOG2_NMAX{mem[old_idx][DATA_WIDTH-1]}}, mem[old_idx]};
    end else begin
      ext_in  = {{LOG2_NMAX{1'b0}}, data_in};
      ext_old = {{LOG2_NMAX{1'b0}}, mem[old_idx]};
    end
    acc_new = acc + ext_in - ((state == S_RUN) ? ext_old : '0);
    rnd     = (ROUND != 0 && k_use != '0) ? (AW'(1) << (k_use - KW'(1))) : '0;
    sum     = acc_new + rnd;
    res_s   = DATA_WIDTH'($signed(sum) >>> k_use);
    res_u   = DATA_WIDTH'(sum >> k_use);

    state_d     = state;
    count_d     = count;
    acc_d       = acc;
    wr_ptr_d    = wr_ptr;
    out_valid_d = 1'b0;
    data_out_d  = data_out;

    if (flush) begin
      state_d  = S_FILL;
      count_d  = '0;
      acc_d    = '0;
      wr_ptr_d = '0;
    end else if (accept) begin
      wr_ptr_d = wr_ptr + PW'(1);
      acc_d    = acc_new;
      if (state == S_FILL) begin
        count_d = count + CW'(1);
        if (count_d == n_win) state_d = S_RUN;
      end
      if (state_d == S_RUN) begin
        out_valid_d = 1'b1;
        data_out_d  = (SIGNED != 0) ? res_s : res_u;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_FILL;
      count     <= '0;
      acc       <= '0;
      wr_ptr    <= '0;
      k_reg     <= '0;
      k_loaded  <= 1'b0;
      out_valid <= 1'b0;
      data_out  <= '0;
    end else begin
      state     <= state_d;
      count     <= count_d;
      acc       <= acc_d;
      wr_ptr    <= wr_ptr_d;
      k_reg     <= k_new;
      k_loaded  <= 1'b1;
      out_valid <= out_valid_d;
      data_out  <= data_out_d;
    end
  end

  // History is never reset; only entries written since the last flush are read back.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= data_in;
  end

  assign filled = (state == S_RUN);

endmodule

// File: tb/tb_moving_average_filter_cfg.sv
// Drives five filter variants in lockstep and scoreboards each against a window-sum reference.
module tb_moving_average_filter_cfg;

  typedef struct packed {
    logic [4:0]      ov;
    logic [4:0]      f;
    logic [4:0][7:0] d;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst, clr, in_valid;
  logic [1:0]      win_sel;
  logic [7:0]      data_in;
  logic [4:0]      dut_ov, dut_f;
  logic [4:0][7:0] dut_d;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // variant: 0 unsigned/floor, 1 signed/floor, 2 signed/round, 3 unsigned/round, 4 LOG2_NMAX=2
  int v_lg[5]  = '{3, 3, 3, 3, 2};
  int v_sgn[5] = '{0, 1, 1, 0, 0};
  int v_rnd[5] = '{0, 0, 1, 1, 0};

  int         m_kreg[5];
  bit         m_loaded[5];
  int         m_cnt[5];
  bit         m_run[5];
  int         m_h[5][8];
  logic [7:0] m_dout[5];

  always #5 clk = ~clk;

  moving_average_filter_cfg u_dut0 (
    .clk(clk), .rst(rst), .clr(clr), .win_sel(win_sel), .in_valid(in_valid), .data_in(data_in),
    .out_valid(dut_ov[0]), .data_out(dut_d[0]), .filled(dut_f[0]));
  moving_average_filter_cfg #(.SIGNED(1)) u_dut1 (
    .clk(clk), .rst(rst), .clr(clr), .win_sel(win_sel), .in_valid(in_valid), .data_in(data_in),
    .out_valid(dut_ov[1]), .data_out(dut_d[1]), .filled(dut_f[1]));
  moving_average_filter_cfg #(.SIGNED(1), .ROUND(1)) u_dut2 (
    .clk(clk), .rst(rst), .clr(clr), .win_sel(win_sel), .in_valid(in_valid), .data_in(data_in),
    .out_valid(dut_ov[2]), .data_out(dut_d[2]), .filled(dut_f[2]));
  moving_average_filter_cfg #(.ROUND(1)) u_dut3 (
    .clk(clk), .rst(rst), .clr(clr), .win_sel(win_sel), .in_valid(in_valid), .data_in(data_in),
    .out_valid(dut_ov[3]), .data_out(dut_d[3]), .filled(dut_f[3]));
  moving_average_filter_cfg #(.LOG2_NMAX(2)) u_dut4 (
    .clk(clk), .rst(rst), .clr(clr), .win_sel(win_sel), .in_valid(in_valid), .data_in(data_in),
    .out_valid(dut_ov[4]), .data_out(dut_d[4]), .filled(dut_f[4]));

  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin
      m_kreg[i] = 0; m_loaded[i] = 1'b0; m_cnt[i] = 0; m_run[i] = 1'b0; m_dout[i] = 8'd0;
    end
  endtask

  // Reference: average of the most recent n accepted samples held as plain integers.
  task automatic model_step(input bit c, input bit v, input logic [7:0] d, input int ws,
                            output exp_t e);
    int kn, ku, n, sum, val;
    bit fl;
    e = '0;
    for (int i = 0; i < 5; i++) begin
      kn = (ws > v_lg[i]) ? v_lg[i] : ws;
      fl = c || (m_loaded[i] && kn != m_kreg[i]);
      ku = m_loaded[i] ? m_kreg[i] : kn;
      m_kreg[i] = kn;
      m_loaded[i] = 1'b1;
      if (fl) begin
        m_cnt[i] = 0;
        m_run[i] = 1'b0;
      end else if (v) begin
        val = (v_sgn[i] != 0 && d[7]) ? int'(d) - 256 : int'(d);
        for (int j = 7; j > 0; j--) m_h[i][j] = m_h[i][j-1];
        m_h[i][0] = val;
        if (m_cnt[i] < 8) m_cnt[i]++;
        n = 1 << ku;
        if (m_cnt[i] >= n) m_run[i] = 1'b1;
        if (m_run[i]) begin
          sum = 0;
          for (int j = 0; j < n; j++) sum += m_h[i][j];
          if (v_rnd[i] != 0 && ku > 0) sum += 1 << (ku - 1);
          sum = sum >>> ku;
          m_dout[i] = sum[7:0];
          e.ov[i] = 1'b1;
        end
      end
      e.f[i] = m_run[i];
      e.d[i] = m_dout[i];
    end
  endtask

  task automatic step(input bit c, input bit v, input logic [7:0] d, input int ws);
    exp_t e;
    clr = c; in_valid = v; data_in = d; win_sel = 2'(ws);
    model_step(c, v, d, ws, e);
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic send_n(input int cnt, input logic [7:0] d, input int ws);
    for (int i = 0; i < cnt; i++) step(1'b0, 1'b1, d, ws);
  endtask

  task automatic chk_reset(input string tag);
    for (int i = 0; i < 5; i++) begin
      checks++;
      assert ({dut_ov[i], dut_f[i], dut_d[i]} === 10'b0) else begin
        errors++;
        $error("FAIL %s[%0d] got ov=%b f=%b d=%0d exp all zero", tag, i, dut_ov[i], dut_f[i], dut_d[i]);
      end
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk); #1;
    rst = 1'b0;
    #1 chk_reset(tag);
    model_reset();
    clr = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      for (int i = 0; i < 5; i++) begin
        checks++;
        assert (dut_ov[i] === e.ov[i]) else begin
          errors++; $error("FAIL out_valid[%0d] got %b exp %b", i, dut_ov[i], e.ov[i]);
        end
        checks++;
        assert (dut_d[i] === e.d[i]) else begin
          errors++; $error("FAIL data_out[%0d] got %0d exp %0d", i, dut_d[i], e.d[i]);
        end
        checks++;
        assert (dut_f[i] === e.f[i]) else begin
          errors++; $error("FAIL filled[%0d] got %b exp %b", i, dut_f[i], e.f[i]);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; win_sel = 2'd2; data_in = 8'd0;
    model_reset();
    #2 rst = 1'b0;
    #2 chk_reset("por");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;

    // constant input, window 4
    step(1'b0, 1'b0, 8'd0, 2);
    send_n(6, 8'd10, 2);

    // ramp
    step(1'b1, 1'b0, 8'd0, 2);
    for (int i = 1; i <= 6; i++) step(1'b0, 1'b1, 8'(10 * i), 2);

    // gaps do not age the window, then flush and flush-with-sample
    step(1'b1, 1'b0, 8'd0, 2);
    send_n(1, 8'd10, 2);
    send_n(1, 8'd20, 2);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'd77, 2);
    send_n(1, 8'd30, 2);
    send_n(1, 8'd40, 2);
    step(1'b1, 1'b0, 8'd0, 2);
    for (int i = 5; i <= 8; i++) step(1'b0, 1'b1, 8'(i), 2);
    step(1'b1, 1'b1, 8'd99, 2);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'd1, 2);

    // window change flushes (clamped variant keeps running), then decay
    step(1'b0, 1'b1, 8'd16, 3);
    send_n(8, 8'd16, 3);
    send_n(8, 8'd0, 3);

    // window of one tracks input
    step(1'b0, 1'b1, 8'd50, 0);
    send_n(1, 8'd3, 0);
    send_n(1, 8'd200, 0);
    send_n(1, 8'd7, 0);
    send_n(1, 8'd128, 0);

    // signed/rounding: -3,-4 with window 2
    step(1'b0, 1'b0, 8'd0, 1);
    send_n(1, 8'd253, 1);
    send_n(1, 8'd252, 1);

    // 1,2,2,2 then full-scale with window 4
    step(1'b0, 1'b0, 8'd0, 2);
    send_n(1, 8'd1, 2);
    send_n(3, 8'd2, 2);
    step(1'b1, 1'b0, 8'd0, 2);
    send_n(4, 8'd255, 2);
    send_n(4, 8'd255, 3);
    step(1'b0, 1'b0, 8'd0, 3);
    send_n(8, 8'd255, 3);

    // async reset mid-fill and mid-run
    step(1'b0, 1'b0, 8'd0, 2);
    send_n(2, 8'd10, 2);
    do_reset("rst_fill");
    step(1'b0, 1'b0, 8'd0, 2);
    send_n(6, 8'd10, 2);
    do_reset("rst_run");
    step(1'b0, 1'b0, 8'd0, 2);
    send_n(6, 8'd10, 2);
    step(1'b0, 1'b0, 8'd0, 2);

    @(negedge clk); #1;
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++; $error("FAIL drain got %0d pending exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
